// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_pkg
// Description : Shared widths, defaults and FSM state type for the HUB75
//               row receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    localparam int DATA_W       = 6;    // R1,G1,B1,R2,G2,B2
    localparam int ROW_W        = 5;    // row address lines A..E
    localparam int COL_W        = 7;    // pixel column index width
    localparam int COLS_DEFAULT = 128;  // columns per captured row

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/hub75_sync.sv
`default_nettype none
// ============================================================================
// Module      : hub75_sync
// Description : Brings the asynchronous HUB75 pins into the clk60 domain
//               through SYNC_STAGES flops (SYNC_STAGES >= 2), followed by one
//               edge-detect register. That register produces one-cycle
//               rising-edge pulses for sclk/lat and keeps data, row and oe
//               aligned cycle-for-cycle with those pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_sync
    import hub75_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk60,
    input  logic              resetn,
    input  logic [DATA_W-1:0] hub_data_i,
    input  logic [ROW_W-1:0]  hub_row_i,
    input  logic              hub_sclk_i,
    input  logic              hub_lat_i,
    input  logic              hub_oe_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ROW_W-1:0]  row_o,
    output logic              oe_o,
    output logic              sclk_rise_o,
    output logic              lat_rise_o
);

    logic [DATA_W-1:0]      data_q [SYNC_STAGES];
    logic [ROW_W-1:0]       row_q  [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] lat_q;
    logic [SYNC_STAGES-1:0] oe_q;

    logic [DATA_W-1:0]      data_e_q;
    logic [ROW_W-1:0]       row_e_q;
    logic                   oe_e_q;
    logic                   sclk_prev_q;
    logic                   lat_prev_q;
    logic                   sclk_rise_q;
    logic                   lat_rise_q;

    // Synchronizer chains; oe idles high (panel blanked) out of reset.
    always_ff @(posedge clk60) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_q[i] <= '0;
                row_q[i]  <= '0;
            end
            sclk_q <= '0;
            lat_q  <= '0;
            oe_q   <= '1;
        end else begin
            data_q[0] <= hub_data_i;
            row_q[0]  <= hub_row_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_q[i] <= data_q[i-1];
                row_q[i]  <= row_q[i-1];
            end
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], hub_sclk_i};
            lat_q  <= {lat_q[SYNC_STAGES-2:0],  hub_lat_i};
            oe_q   <= {oe_q[SYNC_STAGES-2:0],   hub_oe_i};
        end
    end

    // Edge-detect register: rise pulses plus the payload sampled alongside them.
    always_ff @(posedge clk60) begin
        if (!resetn) begin
            data_e_q    <= '0;
            row_e_q     <= '0;
            oe_e_q      <= 1'b1;
            sclk_prev_q <= 1'b0;
            lat_prev_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            lat_rise_q  <= 1'b0;
        end else begin
            data_e_q    <= data_q[SYNC_STAGES-1];
            row_e_q     <= row_q[SYNC_STAGES-1];
            oe_e_q      <= oe_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
            lat_prev_q  <= lat_q[SYNC_STAGES-1];
            sclk_rise_q <= sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
            lat_rise_q  <= lat_q[SYNC_STAGES-1]  & ~lat_prev_q;
        end
    end

    assign data_o      = data_e_q;
    assign row_o       = row_e_q;
    assign oe_o        = oe_e_q;
    assign sclk_rise_o = sclk_rise_q;
    assign lat_rise_o  = lat_rise_q;

endmodule
`default_nettype wire

// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
// Module      : hub75_rx
// Description : HUB75 panel-bus receiver. Shifts pixel words in on sclk,
//               captures a row on lat and replays it as a ready/valid pixel
//               stream. Optional macro HUB75_RX_ONTIME_EN adds a per-row
//               output-enable on-time counter; when it is undefined, ontime
//               is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int COLS        = COLS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk60,
    input  logic              resetn,
    input  logic [DATA_W-1:0] hub_data,
    input  logic [ROW_W-1:0]  hub_row,
    input  logic              hub_sclk,
    input  logic              hub_lat,
    input  logic              hub_oe,
    output logic [DATA_W-1:0] px_data,
    output logic [COL_W-1:0]  px_col,
    output logic [ROW_W-1:0]  px_row,
    output logic              px_last,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [15:0]       ontime
);

    // The column counter must be able to hold COLS itself (the saturated value).
    localparam int CNT_W = $clog2(COLS + 1);

    logic [DATA_W-1:0] w_data;
    logic [ROW_W-1:0]  w_row;
    logic              w_oe;
    logic              w_sclk_rise;
    logic              w_lat_rise;

    hub75_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk60       (clk60),
        .resetn      (resetn),
        .hub_data_i  (hub_data),
        .hub_row_i   (hub_row),
        .hub_sclk_i  (hub_sclk),
        .hub_lat_i   (hub_lat),
        .hub_oe_i    (hub_oe),
        .data_o      (w_data),
        .row_o       (w_row),
        .oe_o        (w_oe),
        .sclk_rise_o (w_sclk_rise),
        .lat_rise_o  (w_lat_rise)
    );

    logic [DATA_W-1:0] shift_q [COLS];
    logic [DATA_W-1:0] hold_q  [COLS];
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]  count_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  px_col_q, px_col_d;
    logic              overflow_q, overflow_d;
    rx_state_t         state_q, state_d;

    logic              w_shift_wr;
    logic              w_shift_ovf;
    logic [COL_W-1:0]  w_wr_idx;
    logic [CNT_W-1:0]  w_cap_cnt;
    logic              w_xfer;
    logic              w_last;
    logic              w_last_xfer;
    logic              w_lat_accept;
    logic              w_lat_drop;

    // Shift first, then latch: a coinciding sclk word is counted in w_cap_cnt.
    assign w_shift_wr   = w_sclk_rise && (col_cnt_q < CNT_W'(COLS));
    assign w_shift_ovf  = w_sclk_rise && !w_shift_wr;
    assign w_wr_idx     = COL_W'(col_cnt_q);
    assign w_cap_cnt    = col_cnt_q + CNT_W'(w_shift_wr);
    assign w_xfer       = (state_q == STREAM) && px_ready;
    assign w_last       = (state_q == STREAM) && ((CNT_W'(px_col_q) + CNT_W'(1)) == count_q);
    assign w_last_xfer  = w_xfer && w_last;
    // A latch landing on the final beat transfer is taken: the buffer frees that edge.
    assign w_lat_accept = w_lat_rise && ((state_q == IDLE) || w_last_xfer);
    assign w_lat_drop   = w_lat_rise && !w_lat_accept;
    assign col_cnt_d    = w_lat_rise ? '0 : w_cap_cnt;

    // Shift buffer write on each in-range sclk edge.
    always_ff @(posedge clk60) begin
        if (w_shift_wr) begin
            shift_q[w_wr_idx] <= w_data;
        end
    end

    // Holding buffer snapshot on an accepted latch, folding in a same-cycle shift.
    always_ff @(posedge clk60) begin
        if (w_lat_accept) begin
            for (int i = 0; i < COLS; i++) begin
                hold_q[i] <= (w_shift_wr && (w_wr_idx == COL_W'(i))) ? w_data : shift_q[i];
            end
        end
    end

    // Stream column: restart at 0 for a new row, step on each accepted beat.
    always_comb begin
        px_col_d = px_col_q;
        if (w_last_xfer || w_lat_accept) begin
            px_col_d = '0;
        end else if (w_xfer) begin
            px_col_d = px_col_q + COL_W'(1);
        end
    end

    // Sticky overflow: a new error in the same cycle as a clear keeps it set.
    always_comb begin
        overflow_d = overflow_q;
        if (w_shift_ovf || w_lat_drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Capture counters, row register, stream column and error flag.
    always_ff @(posedge clk60) begin
        if (!resetn) begin
            col_cnt_q  <= '0;
            count_q    <= '0;
            row_q      <= '0;
            px_col_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            px_col_q   <= px_col_d;
            overflow_q <= overflow_d;
            if (w_lat_accept) begin
                count_q <= w_cap_cnt;
                row_q   <= w_row;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk60) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: an empty row never enters STREAM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_lat_accept && (w_cap_cnt != '0)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (w_last_xfer) begin
                    state_d = (w_lat_accept && (w_cap_cnt != '0)) ? STREAM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; data reads as zero whenever no beat is offered.
    always_comb begin
        px_valid = (state_q == STREAM);
        px_last  = w_last;
        px_data  = '0;
        if (state_q == STREAM) begin
            px_data = hold_q[px_col_q];
        end
    end

    assign px_col   = px_col_q;
    assign px_row   = row_q;
    assign overflow = overflow_q;

`ifdef HUB75_RX_ONTIME_EN
    logic [15:0] on_cnt_q;
    logic [15:0] ontime_q;

    // Count enabled (oe low) cycles; publish and restart on every accepted latch.
    always_ff @(posedge clk60) begin
        if (!resetn) begin
            on_cnt_q <= '0;
            ontime_q <= '0;
        end else if (w_lat_accept) begin
            ontime_q <= on_cnt_q;
            on_cnt_q <= '0;
        end else if (!w_oe && (on_cnt_q != 16'hFFFF)) begin
            on_cnt_q <= on_cnt_q + 16'd1;
        end
    end

    assign ontime = ontime_q;
`else
    logic w_unused_oe;
    assign w_unused_oe = w_oe;
    assign ontime      = '0;
`endif

endmodule
`default_nettype wire
